// File: rtl/avalon_mm_pio_in_irq_if.sv
// avalon_mm_pio_in_irq_if: Avalon-MM slave bus bundle for the interrupt-capable input PIO
//   address    [1:0]  register select (master -> slave)
//   chipselect        slave select, qualifies write (master -> slave)
//   write_n           active-low write strobe (master -> slave)
//   writedata  [31:0] write data (master -> slave)
//   readdata   [31:0] registered read data (slave -> master)
//   irq               level interrupt (slave -> master)
interface avalon_mm_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/avalon_mm_pio_in_irq.sv
// avalon_mm_pio_in_irq: Avalon-MM input PIO with synchroniser, optional debouncer, edge capture and maskable irq
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata, irq)
//   in_port  WIDTH asynchronous external inputs
// Register map: 0 data (RO), 1 reserved (reads 0), 2 irqmask (RW), 3 edgecapture (write-1-to-clear).
module avalon_mm_pio_in_irq #(
    parameter int          WIDTH           = 18,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 0,
    parameter int          EDGE_TYPE       = 0,
    parameter logic [31:0] IRQ_RESET_MASK  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_mm_pio_in_irq_if.slave bus,
    input  logic [WIDTH-1:0]      in_port
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] capture_next;
    logic [31:0]      rd_next;
    logic [31:0]      readdata_q;
    logic             irq_q;
    logic             wr;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = sync_out;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [WIDTH-1:0][CW-1:0] cnt;
            logic [WIDTH-1:0]         stable_q;
            // A bit only follows the synchroniser after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    cnt      <= '0;
                    stable_q <= '0;
                end else begin
                    for (int b = 0; b < WIDTH; b++)
                        if (sync_out[b] == stable_q[b])
                            cnt[b] <= '0;
                        else if (cnt[b] == LAST) begin
                            stable_q[b] <= sync_out[b];
                            cnt[b]      <= '0;
                        end else
                            cnt[b] <= cnt[b] + 1'b1;
                end
            assign stable = stable_q;
        end
    endgenerate

    assign wr = bus.chipselect && !bus.write_n;

    always_comb begin
        detect       = EDGE_TYPE == 0 ? stable & ~prev :
                       EDGE_TYPE == 1 ? ~stable & prev : stable ^ prev;
        clear        = wr && bus.address == 2'd3 ? bus.writedata[WIDTH-1:0] : '0;
        mask_next    = wr && bus.address == 2'd2 ? bus.writedata[WIDTH-1:0] : irqmask;
        // Clearing is applied before the OR so a same-cycle detect keeps the bit set.
        capture_next = (edgecapture & ~clear) | detect;
        rd_next      = bus.address == 2'd0 ? 32'(stable) :
                       bus.address == 2'd2 ? 32'(irqmask) :
                       bus.address == 2'd3 ? 32'(edgecapture) : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            prev        <= '0;
            irqmask     <= IRQ_RESET_MASK[WIDTH-1:0];
            edgecapture <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            prev        <= stable;
            irqmask     <= mask_next;
            edgecapture <= capture_next;
            readdata_q  <= rd_next;
            // Built from the next-state values so irq tracks set/clear/mask writes on the same edge.
            irq_q       <= |(capture_next & mask_next);
        end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_avalon_mm_pio_in_irq.sv
// tb_avalon_mm_pio_in_irq: self-checking bench for avalon_mm_pio_in_irq across four parameter sets
module tb_avalon_mm_pio_in_irq;
    localparam int          DP [4] = '{0, 4, 0, 0};
    localparam int          EP [4] = '{0, 0, 1, 2};
    localparam int          SP [4] = '{2, 2, 2, 3};
    localparam logic [17:0] MP [4] = '{18'h0, 18'h0, 18'h1, 18'h5};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = 32'h0;
    logic [17:0] in_port = 18'h0;
    logic [31:0] rd [4];
    logic        irqs [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    avalon_mm_pio_in_irq_if bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_bus
        assign bus[g].address    = address;
        assign bus[g].chipselect = cs;
        assign bus[g].write_n    = wn;
        assign bus[g].writedata  = wd;
        assign rd[g]             = bus[g].readdata;
        assign irqs[g]           = bus[g].irq;
    end

    avalon_mm_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_RESET_MASK(32'h0))
        u0 (.clk(clk), .reset_n(reset_n), .bus(bus[0]), .in_port(in_port));
    avalon_mm_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_RESET_MASK(32'h0))
        u1 (.clk(clk), .reset_n(reset_n), .bus(bus[1]), .in_port(in_port));
    avalon_mm_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .IRQ_RESET_MASK(32'h1))
        u2 (.clk(clk), .reset_n(reset_n), .bus(bus[2]), .in_port(in_port));
    avalon_mm_pio_in_irq #(.WIDTH(18), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_RESET_MASK(32'h5))
        u3 (.clk(clk), .reset_n(reset_n), .bus(bus[3]), .in_port(in_port));

    // Reference model indexed by edge time t:
    //   sync(t)   = in_port sampled at edge t-(S-1)
    //   stable(t) = sync(t) when D=0; otherwise the value sync held for the last D samples, if different
    //   capture(t) from the edge between stable(t-1) and stable(t-2); readdata(t) from registers at t-1.
    logic [17:0] inh [8];
    logic [17:0] syh [4][8];
    logic [17:0] st0 [4];
    logic [17:0] st1 [4];
    logic [17:0] m_mask [4];
    logic [17:0] m_ec [4];
    logic [31:0] exp_rd [4];
    logic        exp_irq [4];

    always @(posedge clk or negedge reset_n) begin : model
        logic [17:0] sn, stn, det, clr, mn, ecn;
        logic same, w;
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) inh[k] <= '0;
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 8; k++) syh[i][k] <= '0;
                st0[i] <= '0;
                st1[i] <= '0;
                m_ec[i] <= '0;
                m_mask[i] <= MP[i];
                exp_rd[i] <= '0;
                exp_irq[i] <= 1'b0;
            end
        end else begin
            w = cs && !wn;
            for (int k = 1; k < 8; k++) inh[k] <= inh[k-1];
            inh[0] <= in_port;
            for (int i = 0; i < 4; i++) begin
                sn = inh[SP[i]-2];
                stn = st0[i];
                if (DP[i] == 0) stn = sn;
                else for (int b = 0; b < 18; b++) begin
                    same = 1'b1;
                    for (int k = 1; k < DP[i]; k++) if (syh[i][k][b] != syh[i][0][b]) same = 1'b0;
                    if (same && syh[i][0][b] != st0[i][b]) stn[b] = syh[i][0][b];
                end
                det = EP[i] == 0 ? (st0[i] & ~st1[i]) : EP[i] == 1 ? (~st0[i] & st1[i]) : (st0[i] ^ st1[i]);
                clr = (w && address == 2'd3) ? wd[17:0] : 18'h0;
                mn = (w && address == 2'd2) ? wd[17:0] : m_mask[i];
                ecn = (m_ec[i] & ~clr) | det;
                exp_rd[i] <= address == 2'd0 ? {14'h0, st0[i]} : address == 2'd2 ? {14'h0, m_mask[i]} :
                             address == 2'd3 ? {14'h0, m_ec[i]} : 32'h0;
                exp_irq[i] <= |(ecn & mn);
                m_mask[i] <= mn;
                m_ec[i] <= ecn;
                st1[i] <= st0[i];
                st0[i] <= stn;
                for (int k = 1; k < 8; k++) syh[i][k] <= syh[i][k-1];
                syh[i][0] <= sn;
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0; in_port = 18'h3FFFF; address = 2'd0; cs = 1'b0; wn = 1'b1; wd = 32'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'h0 || irqs[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold inst%0d readdata=%h irq=%b expected 00000000/0", i, rd[i], irqs[i]);
            end
        end
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL reset_release inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
        end
        checks++;
        if (rd[0] !== 32'h0003FFFF) begin errors++; $display("FAIL reset_data readdata=%h expected 0003ffff", rd[0]); end
        address = 2'd3;
        @(negedge clk);
        checks++;
        if (rd[0] !== 32'h0003FFFF) begin errors++; $display("FAIL reset_capture readdata=%h expected 0003ffff", rd[0]); end
        cs = 1'b1; wn = 1'b0; wd = 32'h3FFFF;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                errors++;
                $display("FAIL reset_clear inst%0d readdata=%h irq=%b expected %h/%b", i, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
            end
        end
        checks++;
        if (rd[0] !== 32'h0) begin errors++; $display("FAIL reset_w1c readdata=%h expected 00000000", rd[0]); end
    endtask

    task automatic test_irq;
        address = 2'd2; cs = 1'b1; wn = 1'b0; wd = 32'h1; in_port = 18'h0;
        @(negedge clk);
        address = 2'd3; wd = 32'hFFFFFFFF;
        repeat (9) @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (irqs[0] !== 1'b0 || rd[0] !== 32'h0) begin
            errors++; $display("FAIL irq_idle irq=%b readdata=%h expected 0/00000000", irqs[0], rd[0]);
        end
        in_port = 18'h1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL irq_rise inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
            if (c == 1) begin
                checks++;
                if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_early irq=%b expected 0", irqs[0]); end
            end
            if (c == 2) begin
                checks++;
                if (irqs[0] !== 1'b1) begin errors++; $display("FAIL irq_set irq=%b expected 1", irqs[0]); end
            end
            if (c == 3) begin
                checks++;
                if (rd[0] !== 32'h1) begin errors++; $display("FAIL irq_capture readdata=%h expected 00000001", rd[0]); end
            end
        end
        cs = 1'b1; wn = 1'b0; wd = 32'h1;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        checks++;
        if (irqs[0] !== 1'b0) begin errors++; $display("FAIL irq_clear irq=%b expected 0", irqs[0]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (irqs[i] !== exp_irq[i]) begin
                errors++; $display("FAIL irq_clear_model inst%0d irq=%b expected %b", i, irqs[i], exp_irq[i]);
            end
        end
    endtask

    task automatic test_debounce;
        address = 2'd0;
        @(negedge clk);
        in_port[5] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL debounce_short inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
            if (rd[1][5] !== 1'b0) begin
                errors++; $display("FAIL debounce_short_data cyc%0d bit5=%b expected 0", c, rd[1][5]);
            end
            checks++;
            if (c == 2) in_port[5] = 1'b0;
        end
        address = 2'd3;
        @(negedge clk);
        checks++;
        if (rd[1][5] !== 1'b0) begin errors++; $display("FAIL debounce_short_capture bit5=%b expected 0", rd[1][5]); end
        address = 2'd0;
        @(negedge clk);
        in_port[5] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL debounce_long inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
            if (c == 5) begin
                checks++;
                if (rd[1][5] !== 1'b0) begin errors++; $display("FAIL debounce_not_yet bit5=%b expected 0", rd[1][5]); end
                in_port[5] = 1'b0;
            end
            if (c == 6) begin
                checks++;
                if (rd[1][5] !== 1'b1) begin errors++; $display("FAIL debounce_accept bit5=%b expected 1", rd[1][5]); end
            end
        end
    endtask

    task automatic test_edge_types;
        address = 2'd3; cs = 1'b1; wn = 1'b0; wd = 32'hFFFFFFFF;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        in_port[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL edge_rise inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
        end
        checks++;
        if (rd[2][2] !== 1'b0) begin errors++; $display("FAIL fall_ignores_rise bit2=%b expected 0", rd[2][2]); end
        checks++;
        if (rd[3][2] !== 1'b1) begin errors++; $display("FAIL any_rise bit2=%b expected 1", rd[3][2]); end
        cs = 1'b1; wn = 1'b0; wd = 32'hFFFFFFFF;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        @(negedge clk);
        in_port[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL edge_fall inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
        end
        checks++;
        if (rd[2][2] !== 1'b1) begin errors++; $display("FAIL fall_capture bit2=%b expected 1", rd[2][2]); end
        checks++;
        if (rd[3][2] !== 1'b1) begin errors++; $display("FAIL any_fall bit2=%b expected 1", rd[3][2]); end
        checks++;
        if (rd[0][2] !== 1'b0) begin errors++; $display("FAIL rise_ignores_fall bit2=%b expected 0", rd[0][2]); end
    endtask

    task automatic test_set_wins;
        address = 2'd3;
        in_port[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL set_wins_model inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
            if (c == 1) begin cs = 1'b1; wn = 1'b0; wd = 32'h4; end
            if (c == 2) begin cs = 1'b0; wn = 1'b1; end
            if (c == 3) begin
                checks++;
                if (rd[0][2] !== 1'b1) begin errors++; $display("FAIL set_wins bit2=%b expected 1", rd[0][2]); end
            end
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
            address = 2'($urandom);
            cs = 1'($urandom);
            wn = ($urandom_range(0, 2) != 0);
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) in_port = in_port ^ (18'($urandom) & 18'($urandom) & 18'($urandom));
        end
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic test_async_reset;
        address = 2'd2; cs = 1'b1; wn = 1'b0; wd = 32'h5;
        @(negedge clk);
        address = 2'd3; wd = 32'hFFFFFFFF;
        repeat (10) @(negedge clk);
        cs = 1'b0; wn = 1'b1;
        in_port = in_port ^ 18'h5;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd[i] !== exp_rd[i] || irqs[i] !== exp_irq[i]) begin
                    errors++;
                    $display("FAIL pre_reset inst%0d cyc%0d readdata=%h irq=%b expected %h/%b", i, c, rd[i], irqs[i], exp_rd[i], exp_irq[i]);
                end
            end
        end
        checks++;
        if (rd[3] !== 32'h5 || irqs[3] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state readdata=%h irq=%b expected 00000005/1", rd[3], irqs[3]);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'h0 || irqs[i] !== 1'b0) begin
                errors++; $display("FAIL async_reset inst%0d readdata=%h irq=%b expected 00000000/0", i, rd[i], irqs[i]);
            end
        end
        in_port = 18'h0; address = 2'd2;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rd[0] !== 32'h0 || rd[2] !== 32'h1 || rd[3] !== 32'h5) begin
            errors++; $display("FAIL mask_reset readdata0=%h readdata2=%h readdata3=%h expected 0/1/5", rd[0], rd[2], rd[3]);
        end
        address = 2'd3;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'h0 || irqs[i] !== 1'b0 || rd[i] !== exp_rd[i]) begin
                errors++; $display("FAIL post_reset_capture inst%0d readdata=%h irq=%b expected 00000000/0", i, rd[i], irqs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_debounce();
        test_edge_types();
        test_set_wins();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
